// File: rtl/l15_store_merge_buffer.sv
// rtl/l15_store_merge_buffer.sv - write-through store merge buffer feeding the L1.5 NoC request port
//
// Purpose:
//   Collects committed 64-bit stores in a circular buffer, merges a store into
//   the youngest entry when it targets the same 8-byte word, and issues entries
//   in order to the NoC. A credit counter bounds stores issued but not yet acked.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid_i/req_ready_o  store request handshake
//   req_addr_i/data_i/be_i   store byte address (bits [2:0] ignored), data, byte enables
//   noc_valid_o/noc_ready_i  head entry handshake towards the NoC
//   noc_addr_o/data_o/be_o   head entry (word-aligned address), zero while not valid
//   noc_ack_i                one-cycle completion pulse, returns one credit
//   empty_o                  no buffered entries and nothing in flight
//   outstanding_o            stores issued but not yet acked
//   ack_err_o                sticky: ack seen with nothing outstanding
//
// Configuration macro:
//   L15_BIG_ENDIAN_SWAP_EN   byte-reverse noc_data_o and bit-reverse noc_be_o

module l15_store_merge_buffer #(
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 7,
  parameter int ADDR_W          = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [ADDR_W-1:0]                      req_addr_i,
  input  logic [63:0]                            req_data_i,
  input  logic [7:0]                             req_be_i,
  output logic                                   noc_valid_o,
  input  logic                                   noc_ready_i,
  output logic [ADDR_W-1:0]                      noc_addr_o,
  output logic [63:0]                            noc_data_o,
  output logic [7:0]                             noc_be_o,
  input  logic                                   noc_ack_i,
  output logic                                   empty_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   ack_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int WA_W  = ADDR_W - 3;

  logic [WA_W-1:0]  waddr_q [DEPTH];
  logic [WA_W-1:0]  waddr_d [DEPTH];
  logic [63:0]      data_q  [DEPTH];
  logic [63:0]      data_d  [DEPTH];
  logic [7:0]       be_q    [DEPTH];
  logic [7:0]       be_d    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic             ack_err_q, ack_err_d;

  logic [PTR_W-1:0] young;
  logic [WA_W-1:0]  req_waddr;
  logic             issue_ok;
  logic             merge_hit;
  logic             push;
  logic             pop;
  logic [63:0]      head_data;
  logic [7:0]       head_be;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr_i[2:0];
  assign req_waddr        = req_addr_i[ADDR_W-1:3];

  // DEPTH is a power of two, so the pointer subtraction wraps modulo DEPTH.
  assign young    = tail_q - PTR_W'(1);
  assign issue_ok = (count_q != '0) && (outst_q < OUT_W'(MAX_OUTSTANDING));

  // Merging into a presented head would change data mid-handshake, so that
  // case falls back to a normal push.
  assign merge_hit = req_valid_i && (count_q != '0) &&
                     (waddr_q[young] == req_waddr) &&
                     !((young == head_q) && issue_ok);

  // Readiness depends only on registered state and the request itself; a
  // same-cycle pop never makes room for a non-merging store.
  assign req_ready_o = (count_q < CNT_W'(DEPTH)) || merge_hit;
  assign push        = req_valid_i && req_ready_o && !merge_hit;
  assign pop         = issue_ok && noc_ready_i;

  always_comb begin
    waddr_d   = waddr_q;
    data_d    = data_q;
    be_d      = be_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    outst_d   = outst_q;
    ack_err_d = ack_err_q;

    if (merge_hit) begin
      for (int i = 0; i < 8; i++) begin
        if (req_be_i[i]) begin
          data_d[young][8*i +: 8] = req_data_i[8*i +: 8];
        end
      end
      be_d[young] = be_q[young] | req_be_i;
    end

    if (push) begin
      waddr_d[tail_q] = req_waddr;
      data_d[tail_q]  = req_data_i;
      be_d[tail_q]    = req_be_i;
      tail_d          = tail_q + PTR_W'(1);
    end

    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    // A pop and an ack in the same cycle cancel; an ack with nothing in
    // flight and no pop is a protocol error and the count stays at zero.
    if (pop && !noc_ack_i) begin
      outst_d = outst_q + OUT_W'(1);
    end else if (!pop && noc_ack_i) begin
      if (outst_q != '0) begin
        outst_d = outst_q - OUT_W'(1);
      end else begin
        ack_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Entry storage needs no reset: outputs are gated by noc_valid_o and the
  // merge check only looks at entries while count is non-zero.
  always_ff @(posedge clk_i) begin
    waddr_q <= waddr_d;
    data_q  <= data_d;
    be_q    <= be_d;
  end

  assign head_data = data_q[head_q];
  assign head_be   = be_q[head_q];

  assign noc_valid_o = issue_ok;
  assign noc_addr_o  = issue_ok ? {waddr_q[head_q], 3'b000} : '0;

`ifdef L15_BIG_ENDIAN_SWAP_EN
  always_comb begin
    noc_data_o = '0;
    noc_be_o   = '0;
    if (issue_ok) begin
      for (int i = 0; i < 8; i++) begin
        noc_data_o[8*(7-i) +: 8] = head_data[8*i +: 8];
        noc_be_o[7-i]            = head_be[i];
      end
    end
  end
`else
  assign noc_data_o = issue_ok ? head_data : '0;
  assign noc_be_o   = issue_ok ? head_be   : '0;
`endif

  assign empty_o       = (count_q == '0) && (outst_q == '0);
  assign outstanding_o = outst_q;
  assign ack_err_o     = ack_err_q;

endmodule

// File: tb/tb_l15_store_merge_buffer.sv
// tb/tb_l15_store_merge_buffer.sv - scoreboard bench for l15_store_merge_buffer

module tb_l15_store_merge_buffer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic [63:0] req_data_i;
  logic [7:0]  req_be_i;
  logic        noc_valid_o;
  logic        noc_ready_i;
  logic [63:0] noc_addr_o;
  logic [63:0] noc_data_o;
  logic [7:0]  noc_be_o;
  logic        noc_ack_i;
  logic        empty_o;
  logic [2:0]  outstanding_o;
  logic        ack_err_o;

  l15_store_merge_buffer #(.DEPTH(8), .MAX_OUTSTANDING(7), .ADDR_W(64)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_be_i(req_be_i),
    .noc_valid_o(noc_valid_o), .noc_ready_i(noc_ready_i),
    .noc_addr_o(noc_addr_o), .noc_data_o(noc_data_o), .noc_be_o(noc_be_o),
    .noc_ack_i(noc_ack_i), .empty_o(empty_o),
    .outstanding_o(outstanding_o), .ack_err_o(ack_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } txn_t;

  txn_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   hs_cnt   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] out_data(logic [63:0] d);
`ifdef L15_BIG_ENDIAN_SWAP_EN
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = d[8*i +: 8];
    return r;
`else
    return d;
`endif
  endfunction

  function automatic logic [7:0] out_be(logic [7:0] b);
`ifdef L15_BIG_ENDIAN_SWAP_EN
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
`else
    return b;
`endif
  endfunction

  // Monitor: a handshake is committed on the next rising edge.
  always @(negedge clk) begin
    if (!rst_i && noc_valid_o && noc_ready_i) begin
      txn_t t;
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("noc_unexpected_issue", noc_addr_o, 64'h0);
        if (noc_addr_o == 64'h0) chk("noc_unexpected_issue_valid", 64'(noc_valid_o), 64'h0);
      end else begin
        t = exp_q.pop_front();
        chk("noc_addr", noc_addr_o, t.addr);
        chk("noc_data", noc_data_o, t.data);
        chk("noc_be", 64'(noc_be_o), 64'(t.be));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [63:0] a, logic [63:0] d, logic [7:0] b);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    req_be_i    = b;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic push_exp(logic [63:0] a, logic [63:0] d, logic [7:0] b);
    txn_t t;
    t.addr = a & ~64'h7;
    t.data = out_data(d);
    t.be   = out_be(b);
    exp_q.push_back(t);
    push(a, d, b);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    txn_t t;
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0;
    req_be_i = '0; noc_ready_i = 1'b0; noc_ack_i = 1'b0;
    do_reset();

    // Reset state
    chk("rst_empty", 64'(empty_o), 64'h1);
    chk("rst_noc_valid", 64'(noc_valid_o), 64'h0);
    chk("rst_noc_addr", noc_addr_o, 64'h0);
    chk("rst_outstanding", 64'(outstanding_o), 64'h0);
    chk("rst_ack_err", 64'(ack_err_o), 64'h0);
    chk("rst_req_ready", 64'(req_ready_o), 64'h1);

    // Single store, one-cycle latency, credit return
    noc_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 64'h8000_0010;
    #1;
    chk("no_bypass_valid", 64'(noc_valid_o), 64'h0);
    push_exp(64'h8000_0010, 64'h1122334455667788, 8'hFF);
    chk("s1_valid_next", 64'(noc_valid_o), 64'h1);
    chk("s1_addr_next", noc_addr_o, 64'h8000_0010);
    step();
    chk("s1_outstanding1", 64'(outstanding_o), 64'h1);
    chk("s1_valid_after", 64'(noc_valid_o), 64'h0);
    noc_ack_i = 1'b1; step(); noc_ack_i = 1'b0;
    chk("s1_outstanding0", 64'(outstanding_o), 64'h0);
    chk("s1_empty", 64'(empty_o), 64'h1);

    // Merge into youngest entry behind a presented head
    noc_ready_i = 1'b0;
    push_exp(64'h8000_0100, 64'h0123456789ABCDEF, 8'hFF);
    push_exp(64'h8000_0008, 64'hAAAAAAAA_11111111, 8'h0F);
    req_valid_i = 1'b1; req_addr_i = 64'h8000_000C; req_be_i = 8'hF0;
    #1;
    chk("s2_merge_ready", 64'(req_ready_o), 64'h1);
    push(64'h8000_000C, 64'hBBBBBBBB_00000000, 8'hF0);
    exp_q[exp_q.size()-1].data = out_data(64'hBBBBBBBB_11111111);
    exp_q[exp_q.size()-1].be   = out_be(8'hFF);
    chk("s2_head_stable", noc_addr_o, 64'h8000_0100);
    hs0 = hs_cnt;
    noc_ready_i = 1'b1;
    repeat (4) step();
    noc_ready_i = 1'b0;
    chk("s2_handshakes", 64'(hs_cnt - hs0), 64'd2);
    chk("s2_outstanding", 64'(outstanding_o), 64'h2);
    noc_ack_i = 1'b1; step(); step(); noc_ack_i = 1'b0;
    chk("s2_empty", 64'(empty_o), 64'h1);

    // Fill the buffer, refuse a non-merging store, accept a merging one
    for (int i = 0; i < 8; i++) begin
      req_valid_i = 1'b1; req_addr_i = 64'h9000_0000 + 64'(i * 8); req_be_i = 8'hFF;
      #1;
      chk("s3_fill_ready", 64'(req_ready_o), 64'h1);
      push_exp(64'h9000_0000 + 64'(i * 8), 64'(i), 8'hFF);
    end
    req_valid_i = 1'b1; req_addr_i = 64'h9000_1000; req_be_i = 8'hFF;
    #1;
    chk("s3_full_refuse", 64'(req_ready_o), 64'h0);
    req_addr_i = 64'h9000_0038; req_be_i = 8'h01;
    #1;
    chk("s3_full_merge_ready", 64'(req_ready_o), 64'h1);
    push(64'h9000_0038, 64'hEE, 8'h01);
    exp_q[exp_q.size()-1].data = out_data(64'hEE);

    // Reset mid-transfer discards everything
    do_reset();
    chk("s3_rst_empty", 64'(empty_o), 64'h1);
    chk("s3_rst_valid", 64'(noc_valid_o), 64'h0);
    chk("s3_rst_outstanding", 64'(outstanding_o), 64'h0);

    // Credit limit: 10 stores, 7 issue, one ack frees one more
    hs0 = hs_cnt;
    noc_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) push_exp(64'hA000_0000 + 64'(i * 8), 64'hC0DE_0000 + 64'(i), 8'hFF);
    repeat (4) step();
    chk("s4_handshakes7", 64'(hs_cnt - hs0), 64'd7);
    chk("s4_outstanding7", 64'(outstanding_o), 64'd7);
    chk("s4_stall_valid", 64'(noc_valid_o), 64'h0);
    noc_ack_i = 1'b1; step(); noc_ack_i = 1'b0;
    repeat (4) step();
    chk("s4_handshakes8", 64'(hs_cnt - hs0), 64'd8);
    chk("s4_stall_valid2", 64'(noc_valid_o), 64'h0);
    noc_ready_i = 1'b0;
    do_reset();

    // Spurious ack, then pop and ack in the same cycle
    noc_ack_i = 1'b1; step(); noc_ack_i = 1'b0;
    chk("s5_ack_err", 64'(ack_err_o), 64'h1);
    chk("s5_outstanding0", 64'(outstanding_o), 64'h0);
    noc_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(64'hB000_0000 + 64'(i * 8), 64'(i + 100), 8'h3C);
    step(); step();
    chk("s5_outstanding3", 64'(outstanding_o), 64'd3);
    noc_ready_i = 1'b0;
    push_exp(64'hB000_0100, 64'h55, 8'h01);
    chk("s5_valid", 64'(noc_valid_o), 64'h1);
    noc_ready_i = 1'b1; noc_ack_i = 1'b1;
    step();
    noc_ready_i = 1'b0; noc_ack_i = 1'b0;
    chk("s5_pop_ack_outstanding", 64'(outstanding_o), 64'd3);
    chk("s5_ack_err_sticky", 64'(ack_err_o), 64'h1);
    do_reset();
    chk("s5_ack_err_cleared", 64'(ack_err_o), 64'h0);

    // Output lane ordering
    push_exp(64'h8000_0020, 64'h0102030405060708, 8'h01);
`ifdef L15_BIG_ENDIAN_SWAP_EN
    chk("s6_swap_data", noc_data_o, 64'h0807060504030201);
    chk("s6_swap_be", 64'(noc_be_o), 64'h80);
`else
    chk("s6_plain_data", noc_data_o, 64'h0102030405060708);
    chk("s6_plain_be", 64'(noc_be_o), 64'h01);
`endif
    noc_ready_i = 1'b1;
    step(); step();
    noc_ready_i = 1'b0;
    chk("final_queue_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
